// File: rtl/day5_pkg.sv
// Shared constants and state encoding for the day-5 input parser.
package day5_pkg;
    localparam int WIDTH     = 50;
    localparam int NUM_RANGE = 182;
    localparam int NUM_ID    = 1000;
    localparam int RA_W      = 8;
    localparam int IA_W      = 10;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_CR   = 8'h0D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R_LO,
        S_R_HI,
        S_ID,
        S_DONE
    } state_t;
endpackage

// File: rtl/day_5_dec_acc.sv
// Decimal accumulator: acc*10 + digit, wrapping modulo 2^WIDTH.
module day_5_dec_acc #(
    parameter int WIDTH = day5_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             digit_en,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] acc
);
    import day5_pkg::*;

    always_comb begin
        acc_next = acc;
        if (clear) begin
            acc_next = '0;
        end else if (digit_en) begin
            acc_next = (acc << 3) + (acc << 1) + WIDTH'(digit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end
endmodule

// File: rtl/day_5_parser.sv
// Byte-stream loader: decodes "lo-hi" range lines, a blank separator, then IDs,
// and writes them into the range and ID memories for the check stage.
module day_5_parser #(
    parameter int WIDTH     = day5_pkg::WIDTH,
    parameter int NUM_RANGE = day5_pkg::NUM_RANGE,
    parameter int NUM_ID    = day5_pkg::NUM_ID,
    parameter int RA_W      = day5_pkg::RA_W,
    parameter int IA_W      = day5_pkg::IA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             range_we,
    output logic [RA_W-1:0]  range_addr,
    output logic [WIDTH-1:0] range_start,
    output logic [WIDTH-1:0] range_end,
    output logic             id_we,
    output logic [IA_W-1:0]  id_addr,
    output logic [WIDTH-1:0] id_value,
    output logic [RA_W-1:0]  num_ranges,
    output logic [IA_W-1:0]  num_ids,
    output logic             done,
    output logic             error
);
    import day5_pkg::*;

    state_t           state, state_next;
    logic             digit_flag;
    logic [WIDTH-1:0] lo, acc, acc_next, wr_val;
    logic             is_digit, is_dash, is_lf, is_cr;
    logic             acc_clr, acc_en, flag_set, flag_clr, lo_load;
    logic             do_range, do_id, bad, clear_all;
    logic             range_full, id_full;

    assign is_digit   = (in_data >= CH_0) && (in_data <= CH_9);
    assign is_dash    = (in_data == CH_DASH);
    assign is_lf      = (in_data == CH_LF);
    assign is_cr      = (in_data == CH_CR);
    assign range_full = (num_ranges == RA_W'(NUM_RANGE));
    assign id_full    = (num_ids == IA_W'(NUM_ID));
    // a flush on a final digit must include that digit
    assign wr_val     = is_digit ? acc_next : acc;

    day_5_dec_acc #(.WIDTH(WIDTH)) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clear    (acc_clr),
        .digit_en (acc_en),
        .digit    (in_data[3:0]),
        .acc_next (acc_next),
        .acc      (acc)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        flag_set   = 1'b0;
        flag_clr   = 1'b0;
        lo_load    = 1'b0;
        do_range   = 1'b0;
        do_id      = 1'b0;
        bad        = 1'b0;
        clear_all  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_R_LO;
                    clear_all  = 1'b1;
                    acc_clr    = 1'b1;
                    flag_clr   = 1'b1;
                end
            end
            default: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_digit) begin
                        acc_en   = 1'b1;
                        flag_set = 1'b1;
                    end else if (is_dash) begin
                        if (state == S_R_LO && digit_flag) begin
                            lo_load    = 1'b1;
                            acc_clr    = 1'b1;
                            flag_clr   = 1'b1;
                            state_next = S_R_HI;
                        end else begin
                            bad = 1'b1;
                        end
                    end else if (is_lf) begin
                        if (state == S_R_LO) begin
                            if (digit_flag) bad = 1'b1;
                            else            state_next = S_ID;
                        end else if (state == S_R_HI) begin
                            if (digit_flag) begin
                                do_range   = 1'b1;
                                acc_clr    = 1'b1;
                                flag_clr   = 1'b1;
                                state_next = S_R_LO;
                            end else begin
                                bad = 1'b1;
                            end
                        end else if (digit_flag) begin
                            do_id    = 1'b1;
                            acc_clr  = 1'b1;
                            flag_clr = 1'b1;
                        end
                    end else if (!is_cr) begin
                        bad = 1'b1;
                    end

                    if (in_last) begin
                        if (is_digit && state == S_R_HI) do_range = 1'b1;
                        if (is_digit && state == S_ID)   do_id    = 1'b1;
                        // a "lo" with no '-' left dangling at end of file
                        if (state == S_R_LO && (is_digit || (is_cr && digit_flag))) bad = 1'b1;
                        state_next = S_DONE;
                    end

                    if (bad) begin
                        do_range   = 1'b0;
                        do_id      = 1'b0;
                        state_next = S_DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            digit_flag  <= 1'b0;
            lo          <= '0;
            range_we    <= 1'b0;
            range_addr  <= '0;
            range_start <= '0;
            range_end   <= '0;
            id_we       <= 1'b0;
            id_addr     <= '0;
            id_value    <= '0;
            num_ranges  <= '0;
            num_ids     <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state    <= state_next;
            range_we <= 1'b0;
            id_we    <= 1'b0;
            done     <= (state_next == S_DONE);

            if (flag_set)      digit_flag <= 1'b1;
            else if (flag_clr) digit_flag <= 1'b0;

            if (lo_load) lo <= acc;

            if (clear_all) begin
                num_ranges <= '0;
                num_ids    <= '0;
                error      <= 1'b0;
            end

            if (do_range) begin
                if (range_full) begin
                    error <= 1'b1;
                end else begin
                    range_we    <= 1'b1;
                    range_addr  <= num_ranges;
                    range_start <= lo;
                    range_end   <= wr_val;
                    num_ranges  <= num_ranges + 1'b1;
                end
            end

            if (do_id) begin
                if (id_full) begin
                    error <= 1'b1;
                end else begin
                    id_we    <= 1'b1;
                    id_addr  <= num_ids;
                    id_value <= wr_val;
                    num_ids  <= num_ids + 1'b1;
                end
            end

            if (bad) error <= 1'b1;
        end
    end
endmodule
